// File: rtl/riscv_obi_stall_sched_if.sv
// OBI request/grant/response signals between the core-side memory model and the stall scheduler.
// A request is accepted in any cycle where req && gnt; valid_stall is meaningful only in that cycle; rvalid is a one-cycle pulse per retired response.
interface riscv_obi_stall_sched_if #(
    parameter int DELAY_WL = 4
) ();
    logic                req;
    logic                gnt;
    logic                rvalid;
    logic [DELAY_WL-1:0] valid_stall;

    modport master (
        output req,
        output rvalid,
        input  gnt,
        input  valid_stall
    );

    modport slave (
        input  req,
        input  rvalid,
        output gnt,
        output valid_stall
    );
endinterface

// File: rtl/riscv_obi_stall_sched.sv
// Grant/response stall scheduler: delays gnt per request, picks an rvalid delay,
// and withholds gnt while the response FIFO has no free slot.
module riscv_obi_stall_sched #(
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          OUTSTANDING_MAX = 8,
    parameter int          DELAY_WL        = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    riscv_obi_stall_sched_if.slave             bus,
    input  logic                               en_stall_i,
    input  logic [31:0]                        stall_mode_i,
    input  logic [31:0]                        max_stall_i,
    output logic [$clog2(OUTSTANDING_MAX):0]   outstanding_o,
    output logic                               full_o,
    output logic                               err_o,
    output logic                               state_o
);
    localparam int                  OW   = $clog2(OUTSTANDING_MAX) + 1;
    localparam logic [DELAY_WL-1:0] DMAX = '1;
    localparam logic [OW-1:0]       OMAX = OW'(OUTSTANDING_MAX);
    localparam logic [15:0]         SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DELAY_WL-1:0] r_cnt;
    logic [DELAY_WL-1:0] w_next_cnt;
    logic [15:0]         r_lfsr;
    logic [OW-1:0]       r_outstanding;
    logic                r_err;

    logic [DELAY_WL-1:0] w_cap;
    logic [DELAY_WL-1:0] w_rnd_g;
    logic [DELAY_WL-1:0] w_rnd_v;
    logic [DELAY_WL-1:0] w_gd;
    logic [DELAY_WL-1:0] w_vd;
    logic                w_fixed;
    logic                w_random;
    logic                w_gnt;
    logic                w_inc;
    logic                w_fb;

    assign w_cap    = (max_stall_i > 32'(DMAX)) ? DMAX : max_stall_i[DELAY_WL-1:0];
    assign w_fixed  = en_stall_i && (stall_mode_i == 32'd1);
    assign w_random = en_stall_i && (stall_mode_i == 32'd2);
    assign w_rnd_g  = r_lfsr[2*DELAY_WL-1:DELAY_WL];
    assign w_rnd_v  = r_lfsr[DELAY_WL-1:0];
    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_gd = '0;
        w_vd = '0;
        if (w_fixed) begin
            w_gd = w_cap;
            w_vd = w_cap;
        end else if (w_random) begin
            w_gd = (w_rnd_g > w_cap) ? w_cap : w_rnd_g;
            w_vd = (w_rnd_v > w_cap) ? w_cap : w_rnd_v;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= SEED;
        end else if (en_stall_i) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // A full FIFO parks the FSM in WAIT with cnt=0 until a slot frees up.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_gnt        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (w_gd != '0) begin
                        w_next_cnt   = w_gd - DELAY_WL'(1);
                        w_next_state = WAIT;
                    end else if (!full_o) begin
                        w_gnt = 1'b1;
                    end else begin
                        w_next_cnt   = '0;
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.req) begin
                    w_next_cnt   = '0;
                    w_next_state = IDLE;
                end else if (r_cnt != '0) begin
                    w_next_cnt = r_cnt - DELAY_WL'(1);
                end else if (!full_o) begin
                    w_gnt        = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_cnt   = '0;
                w_next_state = IDLE;
            end
        endcase
        if (rst_i) begin
            w_gnt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    assign w_inc = bus.req && w_gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_inc && !bus.rvalid) begin
                r_outstanding <= r_outstanding + OW'(1);
            end else if (!w_inc && bus.rvalid && (r_outstanding != '0)) begin
                r_outstanding <= r_outstanding - OW'(1);
            end
            if (bus.rvalid && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.valid_stall = w_gnt ? w_vd : '0;
    assign outstanding_o   = r_outstanding;
    assign full_o          = (r_outstanding == OMAX);
    assign err_o           = r_err;
    assign state_o         = r_state;
endmodule

// File: tb/tb_riscv_obi_stall_sched.sv
// Self-checking bench for riscv_obi_stall_sched: grant timing and rvalid delays are
// scoreboarded as {grant cycle, delay} entries and checked when gnt appears.
module tb_riscv_obi_stall_sched;
    localparam int NTX = 1000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_stall_i;
    logic [31:0] stall_mode_i;
    logic [31:0] max_stall_i;
    logic [3:0]  outstanding_o;
    logic        full_o;
    logic        err_o;
    logic        state_o;

    riscv_obi_stall_sched_if #(.DELAY_WL(4)) bus ();

    riscv_obi_stall_sched #(
        .LFSR_SEED(16'hACE1),
        .OUTSTANDING_MAX(8),
        .DELAY_WL(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus),
        .en_stall_i(en_stall_i),
        .stall_mode_i(stall_mode_i),
        .max_stall_i(max_stall_i),
        .outstanding_o(outstanding_o),
        .full_o(full_o),
        .err_o(err_o),
        .state_o(state_o)
    );

    // clock / cycle counter
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    logic        sb_en = 1'b1;
    logic [35:0] exp_q[$];
    logic [35:0] sb_e;
    int          gd_a[2][NTX];
    int          vd_a[2][NTX];

    // scoreboard consumer: every grant must match the oldest expected {cycle, delay}
    always @(negedge clk_i) begin
        if (sb_en && !rst_i && bus.gnt) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL gnt_unexpected cyc=%0d valid_stall=%0d", cyc, bus.valid_stall);
            end else begin
                sb_e = exp_q.pop_front();
                total++;
                if (cyc !== int'(sb_e[35:4])) begin
                    bad++;
                    $display("FAIL gnt_cycle got=%0d want=%0d", cyc, sb_e[35:4]);
                end
                total++;
                if (bus.valid_stall !== sb_e[3:0]) begin
                    bad++;
                    $display("FAIL valid_stall got=%0d want=%0d", bus.valid_stall, sb_e[3:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) step();
        rst_i = 1'b0;
    endtask

    task automatic set_mode(input logic en, input logic [31:0] mode, input logic [31:0] mx);
        en_stall_i   = en;
        stall_mode_i = mode;
        max_stall_i  = mx;
    endtask

    task automatic do_txn(input int gd, input logic [3:0] vd, input string name);
        logic got;
        got = 1'b0;
        exp_q.push_back({32'(cyc + gd), vd});
        bus.req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (bus.gnt) begin
                got = 1'b1;
                break;
            end
            step();
        end
        step();
        bus.req = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout got=no_gnt want=gnt", name);
        end
    endtask

    task automatic drain();
        bus.rvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (outstanding_o == 4'd0) break;
            step();
        end
        bus.rvalid = 1'b0;
        total++;
        if (outstanding_o !== 4'd0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL drain got=%0d/err%0b want=0/err0", outstanding_o, err_o);
        end
    endtask

    // scenario tasks
    task automatic test_reset();
        set_mode(1'b0, 32'd0, 32'd0);
        bus.req    = 1'b1;
        bus.rvalid = 1'b0;
        rst_i      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if (bus.gnt !== 1'b0 || bus.valid_stall !== 4'd0) begin
                bad++;
                $display("FAIL reset_gnt got=%0b/%0d want=0/0", bus.gnt, bus.valid_stall);
            end
            step();
        end
        rst_i   = 1'b0;
        bus.req = 1'b0;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 4'd0 || full_o !== 1'b0 || err_o !== 1'b0 || state_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=out%0d full%0b err%0b st%0b want=0000",
                     outstanding_o, full_o, err_o, state_o);
        end
        step();
    endtask

    task automatic test_no_stall();
        set_mode(1'b0, 32'd1, 32'd7);
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(cyc + i), 4'd0});
        bus.req = 1'b1;
        repeat (4) step();
        bus.req = 1'b0;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 4'd4 || full_o !== 1'b0) begin
            bad++;
            $display("FAIL no_stall_outstanding got=%0d want=4", outstanding_o);
        end
        step();
        drain();
    endtask

    task automatic test_mode_other();
        set_mode(1'b1, 32'd5, 32'd9);
        do_txn(0, 4'd0, "mode5");
        set_mode(1'b1, 32'hFFFF_FFFF, 32'd9);
        do_txn(0, 4'd0, "mode_ff");
        drain();
    endtask

    task automatic test_fixed();
        set_mode(1'b1, 32'd1, 32'd3);
        do_txn(3, 4'd3, "fixed3");
        set_mode(1'b1, 32'd1, 32'd100);
        do_txn(15, 4'd15, "fixed_clamp");
        set_mode(1'b1, 32'd1, 32'd0);
        do_txn(0, 4'd0, "fixed0");
        set_mode(1'b0, 32'd0, 32'd0);
        drain();
    endtask

    task automatic test_full();
        int t;
        set_mode(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back({32'(cyc + i), 4'd0});
        bus.req = 1'b1;
        repeat (11) step();
        @(negedge clk_i);
        total++;
        if (full_o !== 1'b1 || outstanding_o !== 4'd8 || bus.gnt !== 1'b0 || state_o !== 1'b1) begin
            bad++;
            $display("FAIL full_hold got=full%0b out%0d gnt%0b st%0b want=full1 out8 gnt0 st1",
                     full_o, outstanding_o, bus.gnt, state_o);
        end
        step();
        t = cyc;
        bus.rvalid = 1'b1;
        exp_q.push_back({32'(t + 1), 4'd0});
        step();
        bus.rvalid = 1'b0;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 4'd7 || full_o !== 1'b0) begin
            bad++;
            $display("FAIL full_release got=%0d want=7", outstanding_o);
        end
        step();
        bus.req = 1'b0;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 4'd8 || full_o !== 1'b1) begin
            bad++;
            $display("FAIL full_refill got=%0d want=8", outstanding_o);
        end
        step();
        drain();
    endtask

    task automatic run_random(input int run);
        int start;
        int n;
        int tmo;
        sb_en = 1'b0;
        set_mode(1'b1, 32'd2, 32'd5);
        bus.req    = 1'b0;
        bus.rvalid = 1'b0;
        do_reset(2);
        bus.req = 1'b1;
        start   = cyc;
        n       = 0;
        tmo     = 0;
        while (n < NTX && tmo < 40) begin
            bus.rvalid = (outstanding_o != 4'd0);
            @(negedge clk_i);
            if (bus.gnt) begin
                gd_a[run][n] = cyc - start;
                vd_a[run][n] = int'(bus.valid_stall);
                n++;
                start = cyc + 1;
                tmo   = 0;
            end else begin
                tmo++;
            end
            step();
        end
        bus.req    = 1'b0;
        bus.rvalid = 1'b0;
        total++;
        if (n != NTX) begin
            bad++;
            $display("FAIL random_count run=%0d got=%0d want=%0d", run, n, NTX);
        end
        set_mode(1'b0, 32'd0, 32'd0);
        drain();
        sb_en = 1'b1;
    endtask

    task automatic test_random();
        int         bad_gd;
        int         bad_vd;
        int         diff;
        logic [5:0] seen_g;
        logic [5:0] seen_v;
        bad_gd = 0;
        bad_vd = 0;
        diff   = 0;
        seen_g = '0;
        seen_v = '0;
        run_random(0);
        run_random(1);
        for (int i = 0; i < NTX; i++) begin
            if (gd_a[0][i] > 5 || gd_a[0][i] < 0) bad_gd++;
            else seen_g[gd_a[0][i]] = 1'b1;
            if (vd_a[0][i] > 5) bad_vd++;
            else seen_v[vd_a[0][i]] = 1'b1;
            if (gd_a[0][i] != gd_a[1][i] || vd_a[0][i] != vd_a[1][i]) diff++;
        end
        total++;
        if (bad_gd !== 0) begin
            bad++;
            $display("FAIL random_gd_cap got=%0d_over want=0", bad_gd);
        end
        total++;
        if (bad_vd !== 0) begin
            bad++;
            $display("FAIL random_vd_cap got=%0d_over want=0", bad_vd);
        end
        total++;
        if (seen_g !== 6'h3F) begin
            bad++;
            $display("FAIL random_gd_spread got=%b want=111111", seen_g);
        end
        total++;
        if (seen_v !== 6'h3F) begin
            bad++;
            $display("FAIL random_vd_spread got=%b want=111111", seen_v);
        end
        total++;
        if (diff !== 0) begin
            bad++;
            $display("FAIL random_repeat got=%0d_diffs want=0", diff);
        end
    endtask

    task automatic test_reset_wait();
        set_mode(1'b0, 32'd0, 32'd0);
        do_txn(0, 4'd0, "pre_wait");
        set_mode(1'b1, 32'd1, 32'd8);
        bus.req = 1'b1;
        step();
        rst_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (state_o !== 1'b1 || outstanding_o !== 4'd1) begin
            bad++;
            $display("FAIL wait_entry got=st%0b out%0d want=st1 out1", state_o, outstanding_o);
        end
        step();
        rst_i   = 1'b0;
        bus.req = 1'b0;
        @(negedge clk_i);
        total++;
        if (bus.gnt !== 1'b0 || state_o !== 1'b0 || outstanding_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_wait got=gnt%0b st%0b out%0d want=gnt0 st0 out0",
                     bus.gnt, state_o, outstanding_o);
        end
        repeat (3) step();
        bus.rvalid = 1'b1;
        step();
        bus.rvalid = 1'b0;
        @(negedge clk_i);
        total++;
        if (err_o !== 1'b1 || outstanding_o !== 4'd0) begin
            bad++;
            $display("FAIL underflow got=err%0b out%0d want=err1 out0", err_o, outstanding_o);
        end
        repeat (3) step();
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%0b want=1", err_o);
        end
        do_reset(1);
        @(negedge clk_i);
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%0b want=0", err_o);
        end
        step();
    endtask

    initial begin
        rst_i      = 1'b1;
        bus.req    = 1'b0;
        bus.rvalid = 1'b0;
        set_mode(1'b0, 32'd0, 32'd0);
        step();
        test_reset();
        test_no_stall();
        test_mode_other();
        test_fixed();
        test_full();
        test_random();
        test_reset_wait();
        repeat (2) step();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL missing_gnt got=%0d_pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
